// File: rtl/fp_ctrl_pkg.sv
// Shared encodings for the fp_pipeline host controller: command ops, FSM states,
// load targets and memory depths.
package fp_ctrl_pkg;

   localparam int RUN_W_DEF        = 16;
   localparam int DEPTH_IMEM_DEF   = 4096;
   localparam int DEPTH_SCALAR_DEF = 64;
   localparam int DEPTH_BATCH_DEF  = 512;
   localparam int DEPTH_ENC_DEF    = 512;

   localparam logic [2:0] OP_LOAD_IMEM   = 3'd0;
   localparam logic [2:0] OP_LOAD_SCALAR = 3'd1;
   localparam logic [2:0] OP_LOAD_BATCH  = 3'd2;
   localparam logic [2:0] OP_RUN         = 3'd3;
   localparam logic [2:0] OP_READ_ENC    = 3'd4;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_LOAD    = 3'd1;
   localparam logic [2:0] ST_RUN     = 3'd2;
   localparam logic [2:0] ST_RD_ADDR = 3'd3;
   localparam logic [2:0] ST_RD_WAIT = 3'd4;
   localparam logic [2:0] ST_RD_OUT  = 3'd5;
   localparam logic [2:0] ST_FINISH  = 3'd6;

   typedef enum logic [1:0] {
      TGT_IMEM   = 2'd0,
      TGT_SCALAR = 2'd1,
      TGT_BATCH  = 2'd2,
      TGT_ENC    = 2'd3
   } target_e;

   function automatic logic is_legal_op(input logic [2:0] op);
      return op <= OP_READ_ENC;
   endfunction

   // Memory a command addresses; RUN has no target and maps to TGT_ENC harmlessly.
   function automatic target_e op_target(input logic [2:0] op);
      case (op)
         OP_LOAD_IMEM:   return TGT_IMEM;
         OP_LOAD_SCALAR: return TGT_SCALAR;
         OP_LOAD_BATCH:  return TGT_BATCH;
         default:        return TGT_ENC;
      endcase
   endfunction

   function automatic logic [11:0] wrap_inc(input logic [11:0] addr, input int depth);
      return (int'(addr) >= depth - 1) ? 12'd0 : addr + 12'd1;
   endfunction

endpackage

// File: rtl/fp_host_ctrl_counter.sv
// Loadable down-counter used to time the RUN phase; last flags the final cycle.
module fp_host_ctrl_counter
   import fp_ctrl_pkg::*;
#(
   parameter int WIDTH = RUN_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             dec,
   output logic             last
);

   logic [WIDTH-1:0] count;

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != '0)) begin
         count <= count - WIDTH'(1);
      end
   end

   assign last = (count == WIDTH'(1));

endmodule

// File: rtl/fp_host_ctrl.sv
// Host-side command controller for fp_pipeline: streams program/data loads,
// times pipeline runs and streams the encoded result memory back out.
module fp_host_ctrl
   import fp_ctrl_pkg::*;
#(
   parameter int RUN_W        = RUN_W_DEF,
   parameter int DEPTH_IMEM   = DEPTH_IMEM_DEF,
   parameter int DEPTH_SCALAR = DEPTH_SCALAR_DEF,
   parameter int DEPTH_BATCH  = DEPTH_BATCH_DEF,
   parameter int DEPTH_ENC    = DEPTH_ENC_DEF
) (
   input  logic             clk,
   input  logic             reset,

   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [RUN_W-1:0] cmd_len,

   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_data,

   output logic             out_valid,
   input  logic             out_ready,
   output logic [15:0]      out_data,

   output logic             busy,
   output logic             done,
   output logic             err,

   output logic             pipe_en,
   output logic             imem_we,
   output logic             imem_re,
   output logic [11:0]      imem_addr,
   output logic [31:0]      imem_data,
   output logic             dmem_we_external_scalar,
   output logic             dmem_re_external_scalar,
   output logic [5:0]       dmem_addr_scalar,
   output logic [15:0]      dmem_data_scalar,
   output logic             dmem_we_external_batch,
   output logic             dmem_re_external_batch,
   output logic [8:0]       dmem_addr_batch,
   output logic [15:0]      dmem_data_batch,
   output logic             dmem_we_external_encoded,
   output logic             dmem_re_external_encoded,
   output logic [8:0]       dmem_addr_encoded,
   output logic [15:0]      dmem_data_encoded,
   input  logic [15:0]      dmem_out_encoded
);

   logic [2:0]       state;
   target_e          target_q;
   logic [RUN_W-1:0] remaining;
   logic [11:0]      addr_q;
   logic             accept;
   logic             beat;
   logic             run_last;

   function automatic int depth_of(input target_e t);
      case (t)
         TGT_IMEM:   return DEPTH_IMEM;
         TGT_SCALAR: return DEPTH_SCALAR;
         TGT_BATCH:  return DEPTH_BATCH;
         default:    return DEPTH_ENC;
      endcase
   endfunction

   // Unknown read data is replaced by zero in simulation so X never leaks downstream.
   function automatic logic [15:0] scrub(input logic [15:0] d);
`ifndef SYNTHESIS
      if ($isunknown(d)) return 16'h0000;
`endif
      return d;
   endfunction

   assign accept = cmd_valid && (state == ST_IDLE);
   assign beat   = in_valid && (state == ST_LOAD);

   fp_host_ctrl_counter #(.WIDTH(RUN_W)) u_run_cnt (
      .clk      (clk),
      .reset    (reset),
      .load     (accept && (cmd_op == OP_RUN)),
      .load_val (cmd_len),
      .dec      (state == ST_RUN),
      .last     (run_last)
   );

   // NOTE: state uses non-blocking assignments only; the memories behind these
   // ports are never cleared on reset, only the control state is.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         target_q  <= TGT_IMEM;
         remaining <= '0;
         addr_q    <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         err       <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  if (!is_legal_op(cmd_op)) begin
                     err <= 1'b1;
                  end else begin
                     target_q  <= op_target(cmd_op);
                     remaining <= cmd_len;
                     addr_q    <= '0;
                     if (cmd_len == '0)              state <= ST_FINISH;
                     else if (cmd_op == OP_RUN)      state <= ST_RUN;
                     else if (cmd_op == OP_READ_ENC) state <= ST_RD_ADDR;
                     else                            state <= ST_LOAD;
                  end
               end
            end
            ST_LOAD: begin
               if (beat) begin
                  addr_q    <= wrap_inc(addr_q, depth_of(target_q));
                  remaining <= remaining - RUN_W'(1);
                  if (remaining == RUN_W'(1)) state <= ST_FINISH;
               end
            end
            ST_RUN: begin
               if (run_last) state <= ST_FINISH;
            end
            ST_RD_ADDR: state <= ST_RD_WAIT;
            ST_RD_WAIT: begin
               out_data  <= scrub(dmem_out_encoded);
               out_valid <= 1'b1;
               state     <= ST_RD_OUT;
            end
            ST_RD_OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  addr_q    <= wrap_inc(addr_q, DEPTH_ENC);
                  remaining <= remaining - RUN_W'(1);
                  state     <= (remaining == RUN_W'(1)) ? ST_FINISH : ST_RD_ADDR;
               end
            end
            ST_FINISH: state <= ST_IDLE;
            default:   state <= ST_IDLE;
         endcase
      end
   end

   assign cmd_ready = (state == ST_IDLE);
   assign in_ready  = (state == ST_LOAD);
   assign busy      = (state != ST_IDLE);
   assign done      = (state == ST_FINISH);
   assign pipe_en   = (state == ST_RUN);
   assign imem_re   = 1'b0;

   // NOTE: every output gets a default first so no path through the case infers a latch.
   always_comb begin
      imem_we                  = 1'b0;
      imem_addr                = '0;
      imem_data                = '0;
      dmem_we_external_scalar  = 1'b0;
      dmem_re_external_scalar  = 1'b0;
      dmem_addr_scalar         = '0;
      dmem_data_scalar         = '0;
      dmem_we_external_batch   = 1'b0;
      dmem_re_external_batch   = 1'b0;
      dmem_addr_batch          = '0;
      dmem_data_batch          = '0;
      dmem_we_external_encoded = 1'b0;
      dmem_re_external_encoded = 1'b0;
      dmem_addr_encoded        = '0;
      dmem_data_encoded        = '0;

      if (beat) begin
         case (target_q)
            TGT_IMEM: begin
               imem_we   = 1'b1;
               imem_addr = addr_q;
               imem_data = in_data;
            end
            TGT_SCALAR: begin
               dmem_we_external_scalar = 1'b1;
               dmem_addr_scalar        = addr_q[5:0];
               dmem_data_scalar        = in_data[15:0];
            end
            TGT_BATCH: begin
               dmem_we_external_batch = 1'b1;
               dmem_addr_batch        = addr_q[8:0];
               dmem_data_batch        = in_data[15:0];
            end
            default: begin
               dmem_we_external_encoded = 1'b1;
               dmem_addr_encoded        = addr_q[8:0];
               dmem_data_encoded        = in_data[15:0];
            end
         endcase
      end

      if (state == ST_RD_ADDR) begin
         dmem_re_external_encoded = 1'b1;
         dmem_addr_encoded        = addr_q[8:0];
      end
   end

endmodule

// File: tb/tb_fp_host_ctrl.sv
// Directed self-checking bench for fp_host_ctrl with a synchronous-read model of
// the encoded result memory.
module tb_fp_host_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [2:0]  cmd_op = 3'd0;
   logic [15:0] cmd_len = 16'd0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_data = 32'd0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] out_data;
   logic        busy, done, err, pipe_en;
   logic        imem_we, imem_re;
   logic [11:0] imem_addr;
   logic [31:0] imem_data;
   logic        we_s, re_s, we_b, re_b, we_e, re_e;
   logic [5:0]  addr_s;
   logic [8:0]  addr_b, addr_e;
   logic [15:0] data_s, data_b, data_e;
   logic [15:0] enc_rd = 16'h0000;
   logic [15:0] enc_mem [0:3];

   int checks = 0;
   int errors = 0;

   fp_host_ctrl dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_len(cmd_len),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .busy(busy), .done(done), .err(err), .pipe_en(pipe_en),
      .imem_we(imem_we), .imem_re(imem_re), .imem_addr(imem_addr), .imem_data(imem_data),
      .dmem_we_external_scalar(we_s), .dmem_re_external_scalar(re_s),
      .dmem_addr_scalar(addr_s), .dmem_data_scalar(data_s),
      .dmem_we_external_batch(we_b), .dmem_re_external_batch(re_b),
      .dmem_addr_batch(addr_b), .dmem_data_batch(data_b),
      .dmem_we_external_encoded(we_e), .dmem_re_external_encoded(re_e),
      .dmem_addr_encoded(addr_e), .dmem_data_encoded(data_e),
      .dmem_out_encoded(enc_rd)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (re_e) enc_rd <= enc_mem[addr_e[1:0]];
   end

   // Passive monitors sampled at the active edge.
   int unsigned cyc = 0, pe_cnt = 0, last_pe = 0, done_cnt = 0, done_cyc = 0;
   int unsigned busy_low = 0, we_b_cnt = 0, we_e_cnt = 0, re_e_cnt = 0;
   int unsigned stab_err = 0, held_cnt = 0;
   logic        hold_prev = 1'b0;
   logic [15:0] hold_data = 16'h0;
   logic [31:0] imem_q [$];
   logic [31:0] imem_d [$];
   logic [5:0]  scal_q [$];
   logic [15:0] rd_q [$];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (pipe_en) begin
         pe_cnt  <= pe_cnt + 1;
         last_pe <= cyc;
         if (!busy) busy_low <= busy_low + 1;
      end
      if (done) begin
         done_cnt <= done_cnt + 1;
         done_cyc <= cyc;
      end
      if (imem_we) begin
         imem_q.push_back({20'd0, imem_addr});
         imem_d.push_back(imem_data);
      end
      if (we_s) scal_q.push_back(addr_s);
      if (we_b) we_b_cnt <= we_b_cnt + 1;
      if (we_e) we_e_cnt <= we_e_cnt + 1;
      if (re_e) re_e_cnt <= re_e_cnt + 1;
      if (hold_prev && (out_data !== hold_data || out_valid !== 1'b1)) stab_err <= stab_err + 1;
      if (out_valid && !out_ready) held_cnt <= held_cnt + 1;
      hold_prev <= out_valid && !out_ready;
      hold_data <= out_data;
      if (out_valid && out_ready) rd_q.push_back(out_data);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [2:0] op, input logic [15:0] len);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_len   = len;
      step();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input int budget, input string tag);
      int n = 0;
      while (done !== 1'b1 && n < budget) begin
         step();
         n++;
      end
      check(tag, {31'd0, done}, 32'd1);
   endtask

   int unsigned snap_pe, snap_done, snap_imem, snap_scal, snap_b, snap_e;
   logic [31:0] words [0:2];

   initial begin
      enc_mem[0] = 16'h1111;
      enc_mem[1] = 16'h2222;
      enc_mem[2] = 16'h3333;
      enc_mem[3] = 16'h4444;
      words[0] = 32'hAAAA_0001;
      words[1] = 32'hBBBB_0002;
      words[2] = 32'hCCCC_0003;

      // Reset state
      step(); step();
      reset = 1'b0;
      #1;
      check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      check("rst_in_ready",  {31'd0, in_ready},  32'd0);
      check("rst_busy",      {31'd0, busy},      32'd0);
      check("rst_done",      {31'd0, done},      32'd0);
      check("rst_err",       {31'd0, err},       32'd0);
      check("rst_pipe_en",   {31'd0, pipe_en},   32'd0);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_data",  {16'd0, out_data},  32'd0);
      check("rst_imem_re",   {31'd0, imem_re},   32'd0);

      // LOAD_IMEM len 3 with gaps between beats
      snap_imem = imem_q.size();
      issue(3'd0, 16'd3);
      check("ld_in_ready", {31'd0, in_ready}, 32'd1);
      check("ld_busy",     {31'd0, busy},     32'd1);
      check("ld_pipe_en",  {31'd0, pipe_en},  32'd0);
      for (int i = 0; i < 3; i++) begin
         #1;
         check("ld_gap_we", {31'd0, imem_we}, 32'd0);
         step();
         in_valid = 1'b1;
         in_data  = words[i];
         #1;
         check("ld_beat_we",   {31'd0, imem_we}, 32'd1);
         check("ld_beat_addr", {20'd0, imem_addr}, i);
         step();
         in_valid = 1'b0;
      end
      check("ld_done_pulse", {31'd0, done}, 32'd1);
      step();
      check("ld_done_clear", {31'd0, done}, 32'd0);
      check("ld_idle_ready", {31'd0, cmd_ready}, 32'd1);
      check("ld_we_count", imem_q.size() - snap_imem, 32'd3);
      for (int i = 0; i < 3; i++) begin
         check("ld_addr_log", imem_q[snap_imem + i], i);
         check("ld_data_log", imem_d[snap_imem + i], words[i]);
      end

      // LOAD_SCALAR len 66 wraps after 64
      snap_scal = scal_q.size();
      snap_b = we_b_cnt;
      snap_e = we_e_cnt;
      snap_imem = imem_q.size();
      issue(3'd1, 16'd66);
      in_valid = 1'b1;
      for (int i = 0; i < 66; i++) begin
         in_data = 32'h0000_0100 + i;
         step();
      end
      in_valid = 1'b0;
      check("sc_done", {31'd0, done}, 32'd1);
      step();
      check("sc_we_count", scal_q.size() - snap_scal, 32'd66);
      check("sc_addr0",  {26'd0, scal_q[snap_scal]},      32'd0);
      check("sc_addr63", {26'd0, scal_q[snap_scal + 63]}, 32'd63);
      check("sc_wrap0",  {26'd0, scal_q[snap_scal + 64]}, 32'd0);
      check("sc_wrap1",  {26'd0, scal_q[snap_scal + 65]}, 32'd1);
      check("sc_batch_we", we_b_cnt - snap_b, 32'd0);
      check("sc_enc_we",   we_e_cnt - snap_e, 32'd0);
      check("sc_imem_we",  imem_q.size() - snap_imem, 32'd0);

      // RUN len 4200
      snap_pe = pe_cnt;
      issue(3'd3, 16'd4200);
      check("run_pipe_en", {31'd0, pipe_en}, 32'd1);
      wait_done(5000, "run_done_timeout");
      step();
      check("run_pe_cycles", pe_cnt - snap_pe, 32'd4200);
      check("run_busy_low",  busy_low, 32'd0);
      check("run_done_lag",  done_cyc, last_pe + 1);
      check("run_pe_off",    {31'd0, pipe_en}, 32'd0);

      // READ_ENC len 4 with out_ready toggling
      snap_e = re_e_cnt;
      issue(3'd4, 16'd4);
      for (int n = 0; n < 200 && done !== 1'b1; n++) begin
         out_ready = ~out_ready;
         step();
      end
      out_ready = 1'b0;
      check("rd_done", {31'd0, done}, 32'd1);
      step();
      check("rd_count", rd_q.size(), 32'd4);
      for (int i = 0; i < 4; i++) check("rd_data", {16'd0, rd_q[i]}, {16'd0, enc_mem[i]});
      check("rd_stable",   stab_err, 32'd0);
      check("rd_held_seen", {31'd0, held_cnt > 0}, 32'd1);
      check("rd_re_count", re_e_cnt - snap_e, 32'd4);

      // Reset mid-RUN at cycle 10 of 100
      snap_pe = pe_cnt;
      snap_done = done_cnt;
      issue(3'd3, 16'd100);
      for (int i = 0; i < 10; i++) step();
      reset = 1'b1;
      step();
      check("abort_pipe_en",   {31'd0, pipe_en},   32'd0);
      check("abort_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      check("abort_busy",      {31'd0, busy},      32'd0);
      reset = 1'b0;
      step(); step(); step();
      check("abort_no_done", done_cnt - snap_done, 32'd0);
      check("abort_pe_cycles", pe_cnt - snap_pe, 32'd11);

      // Illegal op sets sticky err
      issue(3'd7, 16'd5);
      check("bad_err",       {31'd0, err},       32'd1);
      check("bad_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      check("bad_busy",      {31'd0, busy},      32'd0);
      step(); step();
      check("bad_no_done",   done_cnt - snap_done, 32'd0);

      // Zero-length LOAD_BATCH goes straight to FINISH
      snap_b = we_b_cnt;
      issue(3'd2, 16'd0);
      check("zero_done",   {31'd0, done}, 32'd1);
      check("zero_busy",   {31'd0, busy}, 32'd1);
      step();
      check("zero_idle",   {31'd0, cmd_ready}, 32'd1);
      check("zero_no_we",  we_b_cnt - snap_b, 32'd0);
      check("err_sticky",  {31'd0, err}, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
